// File: rtl/store_buffer_pkg.sv
// ============================================================================
// Module      : store_buffer_pkg
// Description : Shared types and helpers for the posted-write store buffer.
//               Defines the buffered-entry layout, the drain FSM state
//               encoding and a modulo pointer-increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_buffer_pkg;

   // Entry field widths. The store_buffer ADDR_W/DATA_W parameters default
   // to these, and the entry layout below is built from them.
   localparam int SB_ADDR_W = 32;
   localparam int SB_DATA_W = 32;

   // One buffered store: word address (byte bits [1:0] dropped) plus data.
   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-3:0] waddr;
      logic [SB_DATA_W-1:0] data;
   } sb_entry_t;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_DRAIN = 2'd1,
      SB_DONE  = 2'd2
   } sb_state_t;

   // Circular pointer increment; callers cast to their pointer width.
   function automatic logic [31:0] wrap_inc(input logic [31:0] ptr,
                                            input logic [31:0] depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sb_forward_match.sv
// ============================================================================
// Module      : sb_forward_match
// Description : Combinational age-ordered search of the store buffer for a
//               load word address. Walks from the oldest entry (head) to the
//               youngest (head+count-1); later matches override earlier ones
//               so the youngest matching store wins.
// Ports       : entries  - buffer entry array
//               head     - index of the oldest entry
//               count    - number of occupied entries
//               ld_waddr - load word address
//               hit      - at least one occupied entry matches
//               data     - data of the youngest matching entry, else 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_forward_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  sb_entry_t              entries [DEPTH],
   input  logic [PTR_W-1:0]       head,
   input  logic [CNT_W-1:0]       count,
   input  logic [SB_ADDR_W-3:0]   ld_waddr,
   output logic                   hit,
   output logic [SB_DATA_W-1:0]   data
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         // Pointer arithmetic wraps naturally because DEPTH is a power of two.
         idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && entries[idx].valid &&
             (entries[idx].waddr == ld_waddr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : Posted-write buffer between the MEM stage and data memory.
//               SW instructions are accepted into a circular FIFO in one
//               cycle and drained to memory over a valid/ready write port.
//               LW lookups are forwarded from the youngest matching buffered
//               store. A drain/fence handshake empties the buffer on request.
// Ports       : clock, reset          - clock, async active-low reset
//               st_valid/addr/data    - store request from MEM
//               st_ready              - store accepted this cycle
//               ld_valid/addr         - load lookup from MEM
//               ld_hit/ld_data        - forwarding result
//               mem_wr_valid/addr/data, mem_wr_ready - memory write port
//               drain_req, drain_done - fence handshake
//               empty, count          - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = SB_ADDR_W,
   parameter int DATA_W = SB_DATA_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   output logic                       st_ready,
   input  logic                       ld_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       ld_hit,
   output logic [DATA_W-1:0]          ld_data,
   output logic                       mem_wr_valid,
   output logic [ADDR_W-1:0]          mem_wr_addr,
   output logic [DATA_W-1:0]          mem_wr_data,
   input  logic                       mem_wr_ready,
   input  logic                       drain_req,
   output logic                       drain_done,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   sb_entry_t        entries [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] occupancy_next;
   sb_state_t        state;
   logic             drain_done_q;

   logic             push;
   logic             pop;
   logic             fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   // Byte-offset bits are ignored for word-only accesses.
   logic unused_byte_bits;
   assign unused_byte_bits = ^{st_addr[1:0], ld_addr[1:0]};

   // ------------------------------------------------------------------------
   // Handshakes and status
   // ------------------------------------------------------------------------
   // st_ready depends only on registered state, so a pop in the same cycle
   // never makes room for a push into a full buffer.
   assign st_ready     = (occupancy < CNT_W'(DEPTH)) && (state == SB_IDLE);
   assign mem_wr_valid = (occupancy != '0);
   assign empty        = (occupancy == '0);
   assign count        = occupancy;
   assign push         = st_valid && st_ready;
   assign pop          = mem_wr_valid && mem_wr_ready;

   assign mem_wr_addr  = mem_wr_valid ? {entries[head].waddr, 2'b00} : '0;
   assign mem_wr_data  = mem_wr_valid ? entries[head].data : '0;

   always_comb begin
      occupancy_next = occupancy;
      case ({push, pop})
         2'b10:   occupancy_next = occupancy + CNT_W'(1);
         2'b01:   occupancy_next = occupancy - CNT_W'(1);
         default: occupancy_next = occupancy;
      endcase
   end

   // ------------------------------------------------------------------------
   // FIFO storage and pointers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         // Push and pop never target the same slot: a pop needs a non-empty
         // buffer and a push a non-full one, so head==tail cannot hold for both.
         if (pop) begin
            entries[head].valid <= 1'b0;
            head <= PTR_W'(wrap_inc(32'(head), 32'(DEPTH)));
         end
         if (push) begin
            entries[tail].valid <= 1'b1;
            entries[tail].waddr <= st_addr[ADDR_W-1:2];
            entries[tail].data  <= st_data;
            tail <= PTR_W'(wrap_inc(32'(tail), 32'(DEPTH)));
         end
         occupancy <= occupancy_next;
      end
   end

   // ------------------------------------------------------------------------
   // Drain FSM
   // ------------------------------------------------------------------------
   // Transitions look at next-cycle occupancy so drain_done is raised in the
   // cycle right after the final pop (or right after the request if nothing
   // is buffered and no store enters alongside the request).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= SB_IDLE;
         drain_done_q <= 1'b0;
      end else begin
         case (state)
            SB_IDLE: begin
               drain_done_q <= 1'b0;
               if (drain_req) begin
                  if (occupancy_next == '0) begin
                     state        <= SB_DONE;
                     drain_done_q <= 1'b1;
                  end else begin
                     state <= SB_DRAIN;
                  end
               end
            end
            SB_DRAIN: begin
               if (occupancy_next == '0) begin
                  state        <= SB_DONE;
                  drain_done_q <= 1'b1;
               end
            end
            SB_DONE: begin
               state        <= SB_IDLE;
               drain_done_q <= 1'b0;
            end
            default: begin
               state        <= SB_IDLE;
               drain_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign drain_done = drain_done_q;

   // ------------------------------------------------------------------------
   // Load forwarding
   // ------------------------------------------------------------------------
   sb_forward_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .CNT_W (CNT_W)
   ) u_forward (
      .entries  (entries),
      .head     (head),
      .count    (occupancy),
      .ld_waddr (ld_addr[ADDR_W-1:2]),
      .hit      (fwd_hit),
      .data     (fwd_data)
   );

   assign ld_hit  = ld_valid && fwd_hit;
   assign ld_data = ld_hit ? fwd_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue-based reference
//               model tracks buffer contents and drain state; a scoreboard
//               of accepted stores is compared against memory writes by a
//               negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   localparam int M_IDLE  = 0;
   localparam int M_DRAIN = 1;
   localparam int M_DONE  = 2;

   typedef struct {
      logic [ADDR_W-3:0] waddr;
      logic [DATA_W-1:0] data;
      int                stamp;
   } tb_ent_t;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              st_valid = 1'b0;
   logic [ADDR_W-1:0] st_addr = '0;
   logic [DATA_W-1:0] st_data = '0;
   logic              st_ready;
   logic              ld_valid = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;
   logic              mem_wr_valid;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_ready = 1'b0;
   logic              drain_req = 1'b0;
   logic              drain_done;
   logic              empty;
   logic [CNT_W-1:0]  count;

   always #5 clock = ~clock;

   store_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .st_valid     (st_valid),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_ready     (st_ready),
      .ld_valid     (ld_valid),
      .ld_addr      (ld_addr),
      .ld_hit       (ld_hit),
      .ld_data      (ld_data),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_ready (mem_wr_ready),
      .drain_req    (drain_req),
      .drain_done   (drain_done),
      .empty        (empty),
      .count        (count)
   );

   // ---------------------------------------------------------------- model
   tb_ent_t buf_q[$];     // modelled buffer contents, oldest first
   tb_ent_t exp_q[$];     // scoreboard: every accepted store, in order
   int      flush_idx = 0;
   int      mstate    = M_IDLE;
   int      cyc       = 0;

   // Shared flags written only by the stimulus process.
   int      phase        = 0;
   bit      lat_chk      = 1'b0;
   bit      final_chk    = 1'b0;
   bit      timeout_flag = 1'b0;

   // Model update at each active edge, from the inputs held during the cycle.
   always @(posedge clock) begin : model
      bit      m_ready;
      bit      do_push;
      bit      do_pop;
      tb_ent_t e;
      if (!reset) begin
         buf_q.delete();
         mstate    = M_IDLE;
         flush_idx = exp_q.size();
      end else begin
         m_ready = (buf_q.size() < DEPTH) && (mstate == M_IDLE);
         do_pop  = (buf_q.size() != 0) && mem_wr_ready;
         do_push = st_valid && m_ready;
         if (do_pop) void'(buf_q.pop_front());
         if (do_push) begin
            e.waddr = st_addr[ADDR_W-1:2];
            e.data  = st_data;
            e.stamp = cyc;
            buf_q.push_back(e);
            exp_q.push_back(e);
         end
         case (mstate)
            M_IDLE:  if (drain_req) mstate = (buf_q.size() == 0) ? M_DONE : M_DRAIN;
            M_DRAIN: if (buf_q.size() == 0) mstate = M_DONE;
            default: mstate = M_IDLE;
         endcase
      end
      cyc = cyc + 1;
   end

   // -------------------------------------------------------------- monitor
   int tests = 0;
   int fails = 0;
   int rd_idx = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin : monitor
      bit                exp_hit;
      logic [DATA_W-1:0] exp_ld;
      if (!reset) begin
         chk("rst_count", 64'(count), 64'd0);
         chk("rst_empty", 64'(empty), 64'd1);
         chk("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
         chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
         chk("rst_drain_done", 64'(drain_done), 64'd0);
         chk("rst_st_ready", 64'(st_ready), 64'd1);
         chk("rst_ld_hit", 64'(ld_hit), 64'd0);
      end else begin
         chk("count", 64'(count), 64'(buf_q.size()));
         chk("empty", 64'(empty), 64'(buf_q.size() == 0));
         chk("wr_valid", 64'(mem_wr_valid), 64'(buf_q.size() != 0));
         chk("st_ready", 64'(st_ready), 64'((buf_q.size() < DEPTH) && (mstate == M_IDLE)));
         chk("drain_done", 64'(drain_done), 64'(mstate == M_DONE));

         // Youngest buffered store to the same word wins.
         exp_hit = 1'b0;
         exp_ld  = '0;
         if (ld_valid) begin
            for (int i = buf_q.size() - 1; i >= 0; i--) begin
               if (buf_q[i].waddr == ld_addr[ADDR_W-1:2]) begin
                  exp_hit = 1'b1;
                  exp_ld  = buf_q[i].data;
                  break;
               end
            end
         end
         chk("ld_hit", 64'(ld_hit), 64'(exp_hit));
         chk("ld_data", 64'(ld_data), 64'(exp_ld));

         if (mem_wr_valid && mem_wr_ready) begin
            if (rd_idx < flush_idx) rd_idx = flush_idx;
            if (rd_idx >= exp_q.size()) begin
               chk("unexpected_write", 64'(mem_wr_addr), 64'hDEAD_0000_0000);
            end else begin
               chk("wr_addr", 64'(mem_wr_addr), 64'({exp_q[rd_idx].waddr, 2'b00}));
               chk("wr_data", 64'(mem_wr_data), 64'(exp_q[rd_idx].data));
               if (lat_chk) chk("wr_latency", 64'(cyc - exp_q[rd_idx].stamp), 64'd1);
               rd_idx++;
            end
         end
      end

      case (phase)
         1: begin
            chk("full_count", 64'(count), 64'd4);
            chk("full_st_ready", 64'(st_ready), 64'd0);
         end
         2: begin
            chk("fwd_young_hit", 64'(ld_hit), 64'd1);
            chk("fwd_young_data", 64'(ld_data), 64'h0000_BBBB);
         end
         3: begin
            chk("fwd_miss_hit", 64'(ld_hit), 64'd0);
            chk("fwd_miss_data", 64'(ld_data), 64'd0);
         end
         default: ;
      endcase

      if (final_chk) begin
         if (rd_idx < flush_idx) rd_idx = flush_idx;
         chk("all_writes_seen", 64'(rd_idx), 64'(exp_q.size()));
      end
      if (timeout_flag) chk("wait_timeout", 64'd1, 64'd0);
   end

   // ------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic wait_idle_empty();
      int n = 0;
      while ((buf_q.size() != 0 || mstate != M_IDLE) && n < 200) begin
         tick();
         n++;
      end
      if (buf_q.size() != 0 || mstate != M_IDLE) begin
         timeout_flag = 1'b1;
         tick();
         timeout_flag = 1'b0;
      end
   endtask

   initial begin
      // Power-on reset.
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      tick();

      // Fill to full, then a dropped fifth push.
      mem_wr_ready = 1'b0;
      push(32'h100, 32'h11);
      push(32'h104, 32'h22);
      push(32'h108, 32'h33);
      push(32'h10C, 32'h44);
      phase = 1;
      push(32'h110, 32'h55);
      phase = 0;
      mem_wr_ready = 1'b1;
      wait_idle_empty();

      // Forwarding priority.
      mem_wr_ready = 1'b0;
      push(32'h200, 32'hAAAA);
      push(32'h200, 32'hBBBB);
      ld_valid = 1'b1;
      ld_addr  = 32'h202;
      phase    = 2;
      tick();
      ld_addr  = 32'h300;
      phase    = 3;
      tick();
      phase    = 0;
      ld_valid = 1'b0;
      mem_wr_ready = 1'b1;
      wait_idle_empty();

      // Concurrent push/pop with pointer wrap.
      lat_chk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ld_valid = 1'b1;
         ld_addr  = 32'h800 + 32'(i) * 4;
         push(32'h800 + 32'(i) * 4, $urandom);
      end
      ld_valid = 1'b0;
      tick();
      lat_chk = 1'b0;

      // Drain with memory ready on alternate cycles; pushes are refused.
      mem_wr_ready = 1'b0;
      push(32'h900, 32'h1);
      push(32'h904, 32'h2);
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      for (int n = 0; n < 40 && mstate != M_IDLE; n++) begin
         st_valid     = 1'b1;
         st_addr      = 32'hA00;
         st_data      = $urandom;
         mem_wr_ready = ~mem_wr_ready;
         tick();
      end
      st_valid = 1'b0;
      mem_wr_ready = 1'b1;
      wait_idle_empty();

      // Drain while already empty.
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      tick();
      tick();

      // Reset mid-operation; nothing buffered before it may be written after.
      mem_wr_ready = 1'b0;
      push(32'hB00, 32'h111);
      push(32'hB04, 32'h222);
      push(32'hB08, 32'h333);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      mem_wr_ready = 1'b1;
      repeat (6) tick();

      // Randomized traffic over a small address pool to provoke matches.
      for (int n = 0; n < 400; n++) begin
         st_valid     = ($urandom_range(0, 1) == 1);
         st_addr      = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         st_data      = $urandom;
         ld_valid     = ($urandom_range(0, 1) == 1);
         ld_addr      = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         mem_wr_ready = ($urandom_range(0, 2) != 0);
         drain_req    = ($urandom_range(0, 24) == 0);
         tick();
      end
      st_valid  = 1'b0;
      ld_valid  = 1'b0;
      drain_req = 1'b0;
      mem_wr_ready = 1'b1;
      wait_idle_empty();

      final_chk = 1'b1;
      tick();
      final_chk = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish by %0t", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire
